// File: rtl/branch_predict_tournament_if.sv
// Fetch/decode lookup, resolve-stage training and statistics bundle for the
// tournament branch predictor.
interface branch_predict_tournament_if #(
    parameter int GHR_LEN = 8
);
    logic               lookup_en;
    logic [31:0]        lookup_pc;
    logic               pred_flush;
    logic               spec_push;
    logic               pred_valid;
    logic               pred_take;
    logic               pred_global;
    logic               pred_local;
    logic               pred_use_global;
    logic [GHR_LEN-1:0] pred_ghr;
    logic               upd_valid;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic [GHR_LEN-1:0] upd_ghr;
    logic               upd_pred_global;
    logic               upd_pred_local;
    logic               upd_pred_take;
    logic               mispredict;
    logic [31:0]        cnt_branch;
    logic [31:0]        cnt_mispred;

    modport master (
        output lookup_en, lookup_pc, pred_flush, spec_push,
        output upd_valid, upd_pc, upd_taken, upd_ghr,
        output upd_pred_global, upd_pred_local, upd_pred_take,
        input  pred_valid, pred_take, pred_global, pred_local, pred_use_global, pred_ghr,
        input  mispredict, cnt_branch, cnt_mispred
    );

    modport slave (
        input  lookup_en, lookup_pc, pred_flush, spec_push,
        input  upd_valid, upd_pc, upd_taken, upd_ghr,
        input  upd_pred_global, upd_pred_local, upd_pred_take,
        output pred_valid, pred_take, pred_global, pred_local, pred_use_global, pred_ghr,
        output mispredict, cnt_branch, cnt_mispred
    );
endinterface

// File: rtl/branch_predict_tournament.sv
// Tournament predictor: per-PC local history + gshare global PHT, arbitrated by
// a per-PC chooser, with speculative GHR recovery and branch/mispredict counters.
module branch_predict_tournament #(
    parameter int PC_IDX_BITS = 6,
    parameter int GHR_LEN     = 8,
    parameter int LHR_LEN     = 6,
    parameter int CTR_BITS    = 2,
    parameter int CH_BITS     = 2
) (
    input logic                        clk,
    input logic                        rst,
    branch_predict_tournament_if.slave bp
);
    localparam int LTAB  = 1 << PC_IDX_BITS;
    localparam int GTAB  = 1 << GHR_LEN;
    localparam int LPTAB = 1 << LHR_LEN;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CH_BITS-1:0]  CH_INIT  = CH_BITS'((1 << (CH_BITS - 1)) - 1);

    logic [LHR_LEN-1:0]  lhr     [LTAB];
    logic [CTR_BITS-1:0] lpht    [LPTAB];
    logic [CTR_BITS-1:0] gpht    [GTAB];
    logic [CH_BITS-1:0]  chooser [LTAB];
    logic [GHR_LEN-1:0]  ghrSpec;
    logic [31:0]         cntBranch;
    logic [31:0]         cntMispred;

    logic [PC_IDX_BITS-1:0] lkLi, upLi;
    logic [GHR_LEN-1:0]     lkGi, upGi;
    logic [LHR_LEN-1:0]     lkLhr, upLhr;
    logic                   lkGlobal, lkLocal, lkUseGlobal;
    logic                   globalOk, localOk;
    logic                   unusedPcBits;

    function automatic logic [CTR_BITS-1:0] ctrStep(input logic [CTR_BITS-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + CTR_BITS'(1);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [CH_BITS-1:0] chStep(input logic [CH_BITS-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + CH_BITS'(1);
        return (c == '0) ? c : c - CH_BITS'(1);
    endfunction

    assign lkLi        = bp.lookup_pc[PC_IDX_BITS+1:2];
    assign lkGi        = bp.lookup_pc[GHR_LEN+1:2] ^ ghrSpec;
    assign upLi        = bp.upd_pc[PC_IDX_BITS+1:2];
    assign upGi        = bp.upd_pc[GHR_LEN+1:2] ^ bp.upd_ghr;
    assign lkLhr       = lhr[lkLi];
    assign upLhr       = lhr[upLi];
    assign lkGlobal    = gpht[lkGi][CTR_BITS-1];
    assign lkLocal     = lpht[lkLhr][CTR_BITS-1];
    assign lkUseGlobal = chooser[lkLi][CH_BITS-1];
    assign globalOk    = (bp.upd_pred_global == bp.upd_taken);
    assign localOk     = (bp.upd_pred_local == bp.upd_taken);
    assign unusedPcBits = ^{bp.lookup_pc, bp.upd_pc};

    assign bp.mispredict  = bp.upd_valid & (bp.upd_taken != bp.upd_pred_take);
    assign bp.cnt_branch  = cntBranch;
    assign bp.cnt_mispred = cntMispred;

    // Non-blocking writes give read-before-write even when upd_pc aliases lookup_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LTAB; i++) begin
                lhr[i]     <= '0;
                chooser[i] <= CH_INIT;
            end
            for (int unsigned i = 0; i < LPTAB; i++) lpht[i] <= CTR_INIT;
            for (int unsigned i = 0; i < GTAB; i++)  gpht[i] <= CTR_INIT;
        end else if (bp.upd_valid) begin
            gpht[upGi]  <= ctrStep(gpht[upGi], bp.upd_taken);
            lpht[upLhr] <= ctrStep(lpht[upLhr], bp.upd_taken);
            lhr[upLi]   <= {upLhr[LHR_LEN-2:0], bp.upd_taken};
            if (globalOk && !localOk)
                chooser[upLi] <= chStep(chooser[upLi], 1'b1);
            else if (localOk && !globalOk)
                chooser[upLi] <= chStep(chooser[upLi], 1'b0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghrSpec <= '0;
        end else if (bp.mispredict) begin
            ghrSpec <= {bp.upd_ghr[GHR_LEN-2:0], bp.upd_taken};
        end else if (bp.spec_push) begin
            ghrSpec <= {ghrSpec[GHR_LEN-2:0], bp.pred_take};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp.pred_valid      <= 1'b0;
            bp.pred_take       <= 1'b0;
            bp.pred_global     <= 1'b0;
            bp.pred_local      <= 1'b0;
            bp.pred_use_global <= 1'b0;
            bp.pred_ghr        <= '0;
        end else if (bp.pred_flush) begin
            bp.pred_valid      <= 1'b0;
            bp.pred_take       <= 1'b0;
            bp.pred_global     <= 1'b0;
            bp.pred_local      <= 1'b0;
            bp.pred_use_global <= 1'b0;
            bp.pred_ghr        <= ghrSpec;
        end else if (bp.lookup_en) begin
            bp.pred_valid      <= 1'b1;
            bp.pred_take       <= lkUseGlobal ? lkGlobal : lkLocal;
            bp.pred_global     <= lkGlobal;
            bp.pred_local      <= lkLocal;
            bp.pred_use_global <= lkUseGlobal;
            bp.pred_ghr        <= ghrSpec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntBranch  <= '0;
            cntMispred <= '0;
        end else if (bp.upd_valid) begin
            if (cntBranch != '1) cntBranch <= cntBranch + 32'd1;
            if (bp.mispredict && cntMispred != '1) cntMispred <= cntMispred + 32'd1;
        end
    end
endmodule
